// File: rtl/cnt_seg_drv.sv
// cnt_seg_drv: display stage for a 4-bit up/down counter.
// Detects counter wrap-around, keeps an 8-bit saturating wrap tally and scans a 4-digit
// common-anode 7-segment display (digit0 = count, digit1/2 = tally low/high nibble,
// digit3 = direction glyph).
//
// Ports:
//   sgd_clk_i   system clock, rising edge
//   sgd_rst_ni  asynchronous reset, active-low
//   sgd_q_i     count value from the counter
//   sgd_en_i    counter enable (1 = counting)
//   sgd_sel_i   counter direction (1 = up, 0 = down)
//   sgd_clr_i   synchronous clear of the wrap tally, active-high
//   sgd_wrap_o  one-cycle pulse on a detected wrap
//   sgd_an_o    digit anodes, active-low, bit i = digit i
//   sgd_seg_o   segments {g,f,e,d,c,b,a}, active-low
//   sgd_dp_o    decimal point, active-low (lit on digit3 while the tally is saturated)
module cnt_seg_drv #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DIV_W       = 16
) (
  input  logic       sgd_clk_i,
  input  logic       sgd_rst_ni,
  input  logic [3:0] sgd_q_i,
  input  logic       sgd_en_i,
  input  logic       sgd_sel_i,
  input  logic       sgd_clr_i,
  output logic       sgd_wrap_o,
  output logic [3:0] sgd_an_o,
  output logic [6:0] sgd_seg_o,
  output logic       sgd_dp_o
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(REFRESH_DIV - 1);

  localparam logic [6:0] GlyphU    = 7'b1000001;
  localparam logic [6:0] GlyphD    = 7'b0100001;
  localparam logic [6:0] GlyphDash = 7'b0111111;
  localparam logic [6:0] GlyphOff  = 7'b1111111;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Input capture pipeline: cnt_s1 = previous sample, cnt_s2 = the one before.
  logic [3:0] cnt_s1_q, cnt_s2_q;
  logic       en_s1_q, sel_s1_q;
  logic       vld_pre_q, valid_q;
  logic       det, det_q, wrap_q;
  logic [7:0] tally_q, tally_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic       dp_q, dp_d;

  // valid_q holds off detection until cnt_s2 holds a real sample, so reset zeros never
  // look like a 0 -> F down-wrap.
  always_comb begin
    det = valid_q && (((cnt_s2_q == 4'hF) && (cnt_s1_q == 4'h0)) ||
                      ((cnt_s2_q == 4'h0) && (cnt_s1_q == 4'hF)));
  end

  always_comb begin
    tally_d = tally_q;
    if (sgd_clr_i) begin
      tally_d = 8'h00;
    end else if (det_q && (tally_q != 8'hFF)) begin
      tally_d = tally_q + 8'd1;
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DivLast) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd0:    glyph = hex2seg(cnt_s1_q);
      2'd1:    glyph = hex2seg(tally_q[3:0]);
      2'd2:    glyph = hex2seg(tally_q[7:4]);
      default: glyph = !en_s1_q ? GlyphDash : (sel_s1_q ? GlyphU : GlyphD);
    endcase
  end

  // Slot 0 of every hold period is blanked so the previous digit never ghosts.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = GlyphOff;
    dp_d  = 1'b1;
    if (div_q != '0) begin
      an_d  = ~(4'(4'b0001 << idx_q));
      seg_d = glyph;
      dp_d  = !((idx_q == 2'd3) && (tally_q == 8'hFF));
    end
  end

  always_ff @(posedge sgd_clk_i or negedge sgd_rst_ni) begin
    if (!sgd_rst_ni) begin
      cnt_s1_q  <= 4'h0;
      cnt_s2_q  <= 4'h0;
      en_s1_q   <= 1'b0;
      sel_s1_q  <= 1'b0;
      vld_pre_q <= 1'b0;
      valid_q   <= 1'b0;
      det_q     <= 1'b0;
      wrap_q    <= 1'b0;
      tally_q   <= 8'h00;
      div_q     <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= GlyphOff;
      dp_q      <= 1'b1;
    end else begin
      cnt_s1_q  <= sgd_q_i;
      cnt_s2_q  <= cnt_s1_q;
      en_s1_q   <= sgd_en_i;
      sel_s1_q  <= sgd_sel_i;
      vld_pre_q <= 1'b1;
      valid_q   <= vld_pre_q;
      det_q     <= det;
      wrap_q    <= det_q;
      tally_q   <= tally_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign sgd_wrap_o = wrap_q;
  assign sgd_an_o   = an_q;
  assign sgd_seg_o  = seg_q;
  assign sgd_dp_o   = dp_q;

endmodule
